// File: rtl/whack_pkg.sv
// whack_pkg: shared constants for the whack-a-mole strike judge.
//   - game-state codes driven on game_state_i by the game controller
//   - judge FSM state encoding, also exported on state_o for debug LEDs
//   - default number of mole holes / board buttons
package whack_pkg;

  localparam int NUM_HOLES_DEF = 16;

  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_START = 2'b01;
  localparam logic [1:0] GS_PLAY  = 2'b10;
  localparam logic [1:0] GS_OVER  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_LOCKED = 2'd3
  } judge_state_t;

endpackage

// File: rtl/whack_judge_button_sync_edge.sv
// button_sync_edge: 2-flop synchroniser for asynchronous button levels,
// followed by a previous-value register for rising-edge detection.
// A level first sampled high at edge N shows up on press_o between
// edges N+1 and N+2, so it is consumed by downstream logic at edge N+2.
// Ports:
//   clock_i  - system clock
//   reset_i  - synchronous active-high clear of all stages
//   level_i  - raw asynchronous levels, 1 = pressed
//   press_o  - one-cycle press indication per bit
module button_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] press_o
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] prev_p2;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      // stage 0/1: metastability filter; stage 2: edge-detect history
      sync_p0 <= level_i;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign press_o = sync_p1 & ~prev_p2;

endmodule

// File: rtl/whack_judge.sv
// whack_judge: judges player strikes against the displayed mole.
// Emits a one-cycle whacked_o pulse on a correct strike and keeps
// saturating hit (score_o) and wrong-button (miss_o) counters.
// Optional build macro WHACK_MISS_PENALTY_EN: each miss also decrements
// score_o, saturating at zero.
// Ports:
//   clock_i      - system clock
//   reset_i      - synchronous active-high reset
//   game_state_i - global game state, GS_PLAY enables judging
//   mole_i       - one-hot mole position, all-zero = no mole
//   buttons_i    - raw asynchronous button levels
//   whacked_o    - one-cycle pulse on a correct strike
//   score_o      - saturating hit count
//   miss_o       - saturating miss count
//   state_o      - judge FSM state for debug LEDs
module whack_judge
  import whack_pkg::*;
#(
  parameter int SCORE_W   = 8,
  parameter int NUM_HOLES = NUM_HOLES_DEF
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [1:0]           game_state_i,
  input  logic [NUM_HOLES-1:0] mole_i,
  input  logic [NUM_HOLES-1:0] buttons_i,
  output logic                 whacked_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [SCORE_W-1:0]   miss_o,
  output logic [1:0]           state_o
);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
    return (v == '0) ? v : v - SCORE_W'(1);
  endfunction

  logic [NUM_HOLES-1:0] press;
  logic [NUM_HOLES-1:0] mole_dec;
  logic                 mole_valid;
  logic [NUM_HOLES-1:0] lock_mole_q;
  judge_state_t         state_q;
  judge_state_t         state_nxt;
  logic                 hit_evt;
  logic                 miss_evt;

  button_sync_edge #(
    .WIDTH (NUM_HOLES)
  ) u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .level_i (buttons_i),
    .press_o (press)
  );

  // x & (x-1) clears the lowest set bit: zero result means at most one bit set
  assign mole_dec   = mole_i - NUM_HOLES'(1);
  assign mole_valid = (mole_i != '0) && ((mole_i & mole_dec) == '0);

  always_comb begin
    state_nxt = state_q;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    if (game_state_i != GS_PLAY) begin
      // leaving play overrides any strike judged this cycle
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_nxt = ST_WAIT;
        ST_WAIT:   if (mole_valid) state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (|(press & mole_i)) begin
            // a correct press in the same cycle masks any wrong presses
            hit_evt   = 1'b1;
            state_nxt = ST_LOCKED;
          end else begin
            miss_evt = |press;
            if (!mole_valid) state_nxt = ST_WAIT;
          end
        end
        // hold off until the mole handler has visibly changed the mole
        ST_LOCKED: if (mole_i != lock_mole_q) state_nxt = ST_WAIT;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      whacked_o   <= 1'b0;
      score_o     <= '0;
      miss_o      <= '0;
      lock_mole_q <= '0;
    end else begin
      state_q   <= state_nxt;
      whacked_o <= hit_evt;
      if (hit_evt) begin
        score_o     <= sat_inc(score_o);
        lock_mole_q <= mole_i;
      end
      if (miss_evt) begin
        miss_o <= sat_inc(miss_o);
`ifdef WHACK_MISS_PENALTY_EN
        score_o <= sat_dec(score_o);
`endif
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_whack_judge.sv
module tb_whack_judge;

  localparam int SMAX = 255;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  game_state_i;
  logic [15:0] mole_i;
  logic [15:0] buttons_i;
  logic        whacked_o;
  logic [7:0]  score_o;
  logic [7:0]  miss_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  whack_judge #(.SCORE_W(8), .NUM_HOLES(16)) dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .game_state_i (game_state_i),
    .mole_i       (mole_i),
    .buttons_i    (buttons_i),
    .whacked_o    (whacked_o),
    .score_o      (score_o),
    .miss_o       (miss_o),
    .state_o      (state_o)
  );

  // Reference model: buttons sampled at each edge go into a 3-deep history;
  // a strike is judged when a level seen two samples ago was low three ago.
  logic [15:0] hist [0:2];
  logic [15:0] m_press;
  logic [15:0] m_lock;
  int          m_state;   // 0 idle, 1 waiting for mole, 2 armed, 3 locked
  int          m_score;
  int          m_miss;
  bit          m_whack;
  bit          m_valid;

  always @(posedge clk) begin
    m_press = hist[1] & ~hist[2];
    if (reset_i) begin
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      m_state = 0; m_score = 0; m_miss = 0; m_whack = 0; m_lock = '0;
    end else begin
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = buttons_i;
      m_whack = 0;
      m_valid = ($countones(mole_i) == 1);
      if (game_state_i != 2'b10) begin
        m_state = 0;
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (m_valid) m_state = 2;
      end else if (m_state == 2) begin
        if ((m_press & mole_i) != 0) begin
          m_whack = 1;
          m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
          m_lock  = mole_i;
          m_state = 3;
        end else begin
          if (m_press != 0) begin
            m_miss = (m_miss < SMAX) ? m_miss + 1 : SMAX;
`ifdef WHACK_MISS_PENALTY_EN
            if (m_score > 0) m_score = m_score - 1;
`endif
          end
          if (!m_valid) m_state = 1;
        end
      end else begin
        if (mole_i != m_lock) m_state = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (whacked_o !== m_whack) begin
        errors++;
        $display("FAIL model_whacked t=%0t actual=%0b expected=%0b", $time, whacked_o, m_whack);
      end
      checks++;
      if (score_o !== 8'(m_score)) begin
        errors++;
        $display("FAIL model_score t=%0t actual=%0d expected=%0d", $time, score_o, m_score);
      end
      checks++;
      if (miss_o !== 8'(m_miss)) begin
        errors++;
        $display("FAIL model_miss t=%0t actual=%0d expected=%0d", $time, miss_o, m_miss);
      end
      checks++;
      if (state_o !== 2'(m_state)) begin
        errors++;
        $display("FAIL model_state t=%0t actual=%0d expected=%0d", $time, state_o, m_state);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

`ifdef WHACK_MISS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  initial begin
    reset_i = 1'b1; game_state_i = 2'b00; mole_i = '0; buttons_i = 16'hFFFF;

    // 1: reset with every button held
    tick(3);
    chk_en = 1'b1;
    check("reset_score", score_o, 0);
    check("reset_miss", miss_o, 0);
    check("reset_whacked", whacked_o, 0);
    check("reset_state", state_o, 0);
    reset_i = 1'b0;
    tick(4);
    buttons_i = '0;
    tick(4);
    check("idle_score", score_o, 0);
    check("idle_miss", miss_o, 0);

    // 2: single correct strike, pulse timing
    game_state_i = 2'b10; mole_i = 16'h0008;
    tick(3);
    check("armed_state", state_o, 2);
    buttons_i = 16'h0008;
    tick(1);
    check("hit_whack_N", whacked_o, 0);
    tick(1);
    check("hit_whack_N1", whacked_o, 0);
    tick(1);
    check("hit_whack_N2", whacked_o, 1);
    check("hit_score", score_o, 1);
    check("hit_state", state_o, 3);
    tick(1);
    check("hit_whack_N3", whacked_o, 0);

    // 3: locked until mole changes
    buttons_i = '0;
    tick(5);
    buttons_i = 16'h0008;
    tick(4);
    check("locked_score", score_o, 1);
    check("locked_state", state_o, 3);
    buttons_i = '0;
    mole_i = '0;
    tick(1);
    check("unlock_state", state_o, 1);
    mole_i = 16'h0008;
    tick(1);
    check("rearm_state", state_o, 2);
    buttons_i = 16'h0008;
    tick(3);
    check("second_score", score_o, 2);
    buttons_i = '0;
    tick(4);

    // 4: correct + wrong together, then wrong alone, then two wrong
    mole_i = 16'h0100;
    tick(3);
    buttons_i = 16'h0104;
    tick(3);
    check("mixed_score", score_o, 3);
    check("mixed_miss", miss_o, 0);
    buttons_i = '0;
    tick(4);
    mole_i = '0;
    tick(2);
    mole_i = 16'h0100;
    tick(2);
    buttons_i = 16'h0001;
    tick(3);
    check("miss_count", miss_o, 1);
    check("miss_score", score_o, 3 - PEN);
    buttons_i = '0;
    tick(3);
    buttons_i = 16'h0003;
    tick(3);
    check("multi_miss", miss_o, 2);
    check("multi_score", score_o, 3 - 2 * PEN);
    buttons_i = '0;
    tick(3);

    // 6: game leaves play on the strike edge
    buttons_i = 16'h0100;
    tick(2);
    game_state_i = 2'b11;
    tick(1);
    check("over_whack", whacked_o, 0);
    check("over_state", state_o, 0);
    check("over_score", score_o, 3 - 2 * PEN);
    check("over_miss", miss_o, 2);
    tick(1);
    check("over_whack2", whacked_o, 0);
    buttons_i = '0;
    tick(3);

    // 5: miss at zero score, then saturation
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0; game_state_i = 2'b10; mole_i = 16'h0008;
    tick(3);
    buttons_i = 16'h0001;
    tick(3);
    check("zero_miss", miss_o, 1);
    check("zero_score", score_o, 0);
    buttons_i = '0;
    tick(2);
    for (int i = 0; i < 300; i++) begin
      buttons_i = 16'h0008;
      tick(3);
      buttons_i = '0; mole_i = '0;
      tick(1);
      mole_i = 16'h0008;
      tick(1);
    end
    tick(2);
    check("sat_score", score_o, 255);
    check("sat_miss", miss_o, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
